ahb_slave_mux: RTL

- AHB-Lite decoder and response multiplexer. Sits directly upstream of the default slave and beside the Triple-DES slave.
- Decodes HADDR into one HSEL per slave.
- Tracks which slave owns the current data phase, and steers that slave's HREADYOUT/HRESP/HRDATA back to the master and to the shared HREADY.
- Any address outside the DES window goes to the default slave.

---
 rtl/ahb_slave_mux.sv | 106 ++++++++++
 1 files changed

// File: rtl/ahb_slave_mux.sv
// AHB-Lite address decoder and data-phase response multiplexer for the DES and default slaves.
// Optional stall watchdog: define AHB_MUX_TIMEOUT_EN to enable.
module ahb_slave_mux #(
    parameter logic [31:0] DES_BASE = 32'h0000_0000,
    parameter logic [31:0] DES_MASK = 32'hFFFF_F000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HREADYOUT_DES,
    input  logic        HRESP_DES,
    input  logic [63:0] HRDATA_DES,
    input  logic        HREADYOUT_DEF,
    input  logic        HRESP_DEF,
    input  logic [63:0] HRDATA_DEF,
    output logic        HSEL_DES,
    output logic        HSEL_DEF,
    output logic        HREADY,
    output logic        HRESP,
    output logic [63:0] HRDATA
);

    typedef enum logic [2:0] {NONE, DES, DEF, ERR1, ERR2} dsel_t;

    dsel_t dsel;
    dsel_t dsel_nxt;
    logic  unused_htrans0;

    // Only HTRANS[1] distinguishes a real transfer from IDLE/BUSY.
    assign unused_htrans0 = HTRANS[0];

    assign HSEL_DES = ((HADDR & DES_MASK) == DES_BASE);
    assign HSEL_DEF = ~HSEL_DES;

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        unique case (dsel)
            DES: begin
                HREADY = HREADYOUT_DES;
                HRESP  = HRESP_DES;
                HRDATA = HRDATA_DES;
            end
            DEF: begin
                HREADY = HREADYOUT_DEF;
                HRESP  = HRESP_DEF;
                HRDATA = HRDATA_DEF;
            end
            ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            ERR2: begin
                HRESP  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef AHB_MUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic             slave_stall;
    logic             wdog_hit;
    logic [CNT_W-1:0] stall_cnt;

    assign slave_stall = ((dsel == DES) || (dsel == DEF)) && !HREADY;
    // Fires on the TIMEOUT-th consecutive stalled cycle, so ERR1 follows it directly.
    assign wdog_hit    = slave_stall && (stall_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            stall_cnt <= '0;
        else if (HREADY)
            stall_cnt <= '0;
        else if (slave_stall && (stall_cnt != CNT_W'(TIMEOUT)))
            stall_cnt <= stall_cnt + 1'b1;
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    always_comb begin
        dsel_nxt = dsel;
        if (HREADY)
            dsel_nxt = HTRANS[1] ? (HSEL_DES ? DES : DEF) : NONE;
`ifdef AHB_MUX_TIMEOUT_EN
        if (dsel == ERR1)
            dsel_nxt = ERR2;
        else if (wdog_hit)
            dsel_nxt = ERR1;
`endif
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            dsel <= NONE;
        else
            dsel <= dsel_nxt;
    end

endmodule
